// File: rtl/caf_peak_detect_if.sv
// Stream bundle for the CAF peak detector: complex beats in, peak result out.
// The slave view belongs to the detector; the master view drives it.
interface caf_peak_detect_if #(
  parameter int IQ_WIDTH  = 16,
  parameter int IDX_WIDTH = 6
);
  logic [2*IQ_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [2*IQ_WIDTH-1:0] m_axis_tdata;
  logic [IDX_WIDTH-1:0]  m_axis_tuser;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/caf_peak_detect.sv
// Per-frame peak search over CAF output: |x|^2 per beat, max/argmax over
// FRAME_LEN beats, one result beat per frame.
module caf_peak_detect #(
  parameter int IQ_WIDTH  = 16,
  parameter int FRAME_LEN = 64,
  parameter int IDX_WIDTH = $clog2(FRAME_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  caf_peak_detect_if.slave   axis
);
  localparam int MW = 2 * IQ_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]           r_state;
  logic [IDX_WIDTH-1:0] r_beat_cnt;
  logic                 w_accept;

  logic [MW-1:0]        w_sq [2];
  logic [MW-1:0]        r_s1_sq [2];
  logic [IDX_WIDTH-1:0] r_s1_idx;
  logic                 r_s1_valid;

  logic [MW-1:0]        r_s2_mag;
  logic [IDX_WIDTH-1:0] r_s2_idx;
  logic                 r_s2_valid;

  logic [MW-1:0]        r_peak_mag;
  logic [IDX_WIDTH-1:0] r_peak_idx;
  logic                 r_cmp_valid;
  logic                 r_cmp_last;

  logic [MW-1:0]        r_out_mag;
  logic [IDX_WIDTH-1:0] r_out_idx;

  assign w_accept = axis.s_axis_tvalid && (r_state == ST_ACCUM);

  // Lane 0 is Q (low half), lane 1 is I (high half); squares are never negative.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [IQ_WIDTH-1:0] w_comp;
      logic signed [MW-1:0]       w_prod;
      assign w_comp   = axis.s_axis_tdata[gi*IQ_WIDTH +: IQ_WIDTH];
      assign w_prod   = w_comp * w_comp;
      assign w_sq[gi] = $unsigned(w_prod);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= (r_beat_cnt == LAST_IDX) ? '0 : r_beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sq[0] <= '0;
      r_s1_sq[1] <= '0;
      r_s1_idx   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sq[0] <= w_sq[0];
        r_s1_sq[1] <= w_sq[1];
        r_s1_idx   <= r_beat_cnt;
      end
    end
  end

  // Sum of two squares peaks at exactly 2^(MW-1), so MW bits never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_mag   <= '0;
      r_s2_idx   <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mag <= r_s1_sq[0] + r_s1_sq[1];
        r_s2_idx <= r_s1_idx;
      end
    end
  end

  // Beat 0 always loads, which doubles as the per-frame clear; strict > keeps
  // the earliest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_mag  <= '0;
      r_peak_idx  <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_last  <= 1'b0;
    end else begin
      r_cmp_valid <= r_s2_valid;
      r_cmp_last  <= r_s2_valid && (r_s2_idx == LAST_IDX);
      if (r_s2_valid && ((r_s2_idx == '0) || (r_s2_mag > r_peak_mag))) begin
        r_peak_mag <= r_s2_mag;
        r_peak_idx <= r_s2_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACCUM;
      r_out_mag <= '0;
      r_out_idx <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept && (r_beat_cnt == LAST_IDX)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_cmp_valid && r_cmp_last) begin
            r_state   <= ST_OUT;
            r_out_mag <= r_peak_mag;
            r_out_idx <= r_peak_idx;
          end
        end
        ST_OUT: begin
          if (axis.m_axis_tready) begin
            r_state <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign axis.s_axis_tready = (r_state == ST_ACCUM);
  assign axis.m_axis_tvalid = (r_state == ST_OUT);
  assign axis.m_axis_tdata  = r_out_mag;
  assign axis.m_axis_tuser  = r_out_idx;

endmodule

// File: tb/tb_caf_peak_detect.sv
// Directed bench for caf_peak_detect: frames with hand-computed peaks,
// backpressure, input gaps and mid-frame reset.
module tb_caf_peak_detect;
  localparam int IQW = 16;
  localparam int FL  = 64;
  localparam int IW  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   early_seen;
  logic [31:0] frame_mem [FL];

  always #5 clk = ~clk;

  caf_peak_detect_if #(.IQ_WIDTH(IQW), .IDX_WIDTH(IW)) bus ();

  caf_peak_detect #(.IQ_WIDTH(IQW), .FRAME_LEN(FL), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axis  (bus)
  );

  function automatic logic [31:0] pk(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = i[15:0];
    b = q[15:0];
    return {a, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends beats 0..nbeats-1 of frame_mem; returns at the negedge after the last accept.
  task automatic send_frame(input int nbeats, input int gap_pct);
    int n = 0;
    int guard = 0;
    bit acc;
    early_seen = 1'b0;
    while (n < nbeats && guard < 3000) begin
      @(negedge clk);
      if (bus.m_axis_tvalid) early_seen = 1'b1;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.s_axis_tvalid = 1'b0;
      end else begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = frame_mem[n];
      end
      acc = bus.s_axis_tvalid && bus.s_axis_tready;
      @(posedge clk);
      if (acc) n++;
      guard++;
    end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] emag, input logic [5:0] eidx);
    int lat = 0;
    chk({tag, "_s_tready_low"}, bus.s_axis_tready, 1'b0);
    while (!bus.m_axis_tvalid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_tdata"}, bus.m_axis_tdata, emag);
    chk({tag, "_tuser"}, bus.m_axis_tuser, eidx);
  endtask

  task automatic after_handshake(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_tvalid_drop"}, bus.m_axis_tvalid, 1'b0);
    chk({tag, "_s_tready_back"}, bus.s_axis_tready, 1'b1);
  endtask

  initial begin
    int stable;
    logic [31:0] hold_data;
    logic [5:0]  hold_user;

    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", bus.s_axis_tready, 1'b1);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", bus.m_axis_tdata, 32'd0);
    chk("rst_m_tuser", bus.m_axis_tuser, 6'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp: 63^2 = 3969 at index 63
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(n, 0);
    send_frame(FL, 0);
    expect_result("ramp", 32'd3969, 6'd63);
    after_handshake("ramp");

    // Tie at 25 between beats 5, 20, 40: earliest wins
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(1, 1);
    frame_mem[5]  = pk(-3, 4);
    frame_mem[20] = pk(5, 0);
    frame_mem[40] = pk(0, -5);
    send_frame(FL, 0);
    expect_result("tie", 32'd25, 6'd5);
    after_handshake("tie");

    // Extreme: (-32768)^2*2 = 2^31 beats 2*32767^2 = 0x7FFE0002
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(32767, 32767);
    frame_mem[10] = pk(-32768, -32768);
    send_frame(FL, 0);
    expect_result("extreme", 32'h8000_0000, 6'd10);
    after_handshake("extreme");

    // Backpressure: descending ramp peaks at beat 0 with 63^2
    bus.m_axis_tready = 1'b0;
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(63 - n, 0);
    send_frame(FL, 0);
    expect_result("bp", 32'd3969, 6'd0);
    hold_data = bus.m_axis_tdata;
    hold_user = bus.m_axis_tuser;
    stable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid && !bus.s_axis_tready &&
          bus.m_axis_tdata == hold_data && bus.m_axis_tuser == hold_user) stable++;
    end
    chk("bp_stable_cycles", stable, 20);
    chk("bp_tdata_held", bus.m_axis_tdata, 32'd3969);
    bus.m_axis_tready = 1'b1;
    after_handshake("bp");
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(2, 0);
    send_frame(FL, 0);
    expect_result("bp2", 32'd4, 6'd0);
    after_handshake("bp2");

    // Gapped input: beat 37 = 200^2+150^2 = 62500; others at most 32^2+7^2
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(n - 32, 7);
    frame_mem[37] = pk(-200, 150);
    send_frame(FL, 50);
    chk("gap_no_early_result", early_seen, 1'b0);
    expect_result("gap", 32'd62500, 6'd37);
    after_handshake("gap");
    repeat (5) @(negedge clk);
    chk("gap_single_result", bus.m_axis_tvalid, 1'b0);

    // Reset after beat 30 = {100,0}; partial frame must vanish
    for (int n = 0; n < FL; n++) frame_mem[n] = pk(1, 0);
    frame_mem[30] = pk(100, 0);
    send_frame(31, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_tready", bus.s_axis_tready, 1'b1);
    chk("mid_rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("mid_rst_m_tdata", bus.m_axis_tdata, 32'd0);
    chk("mid_rst_m_tuser", bus.m_axis_tuser, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame_mem[30] = pk(1, 0);
    send_frame(FL, 0);
    expect_result("post_rst", 32'd1, 6'd0);
    after_handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
